shift_add_mult_seq: RTL and testbench



---
 rtl/shift_add_mult_seq_pkg.sv | 14 +
 rtl/shift_add_mult_seq_if.sv | 30 +++
 rtl/shift_add_mult_seq_datapath.sv | 50 +++++
 rtl/shift_add_mult_seq.sv | 86 ++++++++
 tb/tb_shift_add_mult_seq.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult_seq_pkg.sv
// Shared types for the shift-and-add multiply sequencer.
// FSM state encodings and default operand width.
package shift_add_mult_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mult_seq_if.sv
// Request/result bundle of the multiply sequencer.
// master issues operands; slave returns busy/done/product.
interface shift_add_mult_seq_if
  import shift_add_mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               dp_load;
  logic               dp_ctrl;

  modport master (
    output start, a_in, b_in,
    input  busy, done, product,
    input  dp_load, dp_ctrl
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, product,
    output dp_load, dp_ctrl
  );

endinterface

// File: rtl/shift_add_mult_seq_datapath.sv
// Shift-and-add multiplier datapath: P/Q/M/C registers,
// adder and right shifter of {C,P,Q}.
module shift_add_datapath
  import shift_add_mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               ctrl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] pq
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             c;
  logic [WIDTH:0]   sum;

  // Add and shift happen in one edge, so the carry lands in
  // P's MSB right away and C only ever holds zero between edges.
  always_comb begin
    sum = {c, p};
    if (q[0]) sum = {1'b0, p} + {1'b0, m};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      q <= '0;
      m <= '0;
      c <= 1'b0;
    end else if (load) begin
      m <= a;
      q <= b;
      p <= '0;
      c <= 1'b0;
    end else if (ctrl) begin
      p <= sum[WIDTH:1];
      q <= {sum[0], q[WIDTH-1:1]};
      c <= 1'b0;
    end
  end

  assign pq = {p, q};

endmodule

// File: rtl/shift_add_mult_seq.sv
// Start/busy/done sequencer around the shift-and-add datapath.
// Runs exactly WIDTH iterations per accepted start.
module shift_add_mult_seq
  import shift_add_mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  shift_add_mult_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_cap;
  logic [WIDTH-1:0]   b_cap;
  logic [2*WIDTH-1:0] pq;
  logic [2*WIDTH-1:0] product;
  logic               done;
  logic               load;
  logic               ctrl;

  shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .ctrl  (ctrl),
    .a     (a_cap),
    .b     (b_cap),
    .pq    (pq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    ctrl    = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_n = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        ctrl = 1'b1;
        if (cnt == '0) state_n = FIN;
      end
      FIN: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_cap   <= '0;
      b_cap   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == IDLE && bus.start) begin
        a_cap <= bus.a_in;
        b_cap <= bus.b_in;
      end
      if (state == LOAD) cnt <= CNT_W'(WIDTH - 1);
      if (state == RUN)  cnt <= cnt - CNT_W'(1);
      if (state == FIN)  product <= pq;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.product = product;
  assign bus.dp_load = load;
  assign bus.dp_ctrl = ctrl;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed bench for shift_add_mult_seq (WIDTH=4 and WIDTH=8).
module tb_shift_add_mult_seq;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  int   cyc;

  shift_add_mult_seq_if #(.WIDTH(4)) bus4 ();
  shift_add_mult_seq_if #(.WIDTH(8)) bus8 ();

  shift_add_mult_seq #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  shift_add_mult_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    bit         tog;
    string      nm;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // tog: zero operands and pulse start while running
  task automatic op(input logic [3:0] a,
                    input logic [3:0] b,
                    input bit tog,
                    output logic [7:0] prod,
                    output int lat,
                    output int nbusy,
                    output int nctrl,
                    output int nover);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a_in  = a;
    bus4.b_in  = b;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = -1; nbusy = 0; nctrl = 0; nover = 0;
    for (int n = 0; n < 30; n++) begin
      if (bus4.done) begin
        lat = n;
        break;
      end
      nbusy += int'(bus4.busy);
      nctrl += int'(bus4.dp_ctrl);
      nover += int'(bus4.dp_ctrl & bus4.dp_load);
      if (tog && n == 2) begin
        bus4.a_in  = 4'd0;
        bus4.b_in  = 4'd0;
        bus4.start = 1'b1;
      end
      if (tog && n == 3) bus4.start = 1'b0;
      @(posedge clk); #1;
    end
    prod = bus4.product;
  endtask

  logic [7:0] prod;
  int lat, nbusy, nctrl, nover, ndone, last, w;
  logic [3:0] ca[3];
  logic [3:0] cb[3];
  logic [7:0] cp[3];

  initial begin
    passed = 0;
    total  = 0;
    vecs[0] = '{4'd3,  4'd12, 8'h24, 1'b0, "3x12"};
    vecs[1] = '{4'd15, 4'd15, 8'hE1, 1'b1, "15x15"};
    vecs[2] = '{4'd0,  4'd9,  8'h00, 1'b0, "0x9"};
    vecs[3] = '{4'd9,  4'd0,  8'h00, 1'b0, "9x0"};
    vecs[4] = '{4'd2,  4'd3,  8'h06, 1'b0, "2x3"};
    ca = '{4'd5, 4'd6, 4'd15};
    cb = '{4'd7, 4'd6, 4'd1};
    cp = '{8'd35, 8'd36, 8'd15};

    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    #12;
    chk("rst_busy", 32'(bus4.busy), 0);
    chk("rst_done", 32'(bus4.done), 0);
    chk("rst_product", 32'(bus4.product), 0);
    chk("rst_dp_load", 32'(bus4.dp_load), 0);
    chk("rst_dp_ctrl", 32'(bus4.dp_ctrl), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].tog,
         prod, lat, nbusy, nctrl, nover);
      chk({vecs[i].nm, "_product"}, 32'(prod), 32'(vecs[i].p));
      chk({vecs[i].nm, "_latency"}, 32'(lat), 6);
      chk({vecs[i].nm, "_busy_cyc"}, 32'(nbusy), 6);
      chk({vecs[i].nm, "_ctrl_cyc"}, 32'(nctrl), 4);
      chk({vecs[i].nm, "_overlap"}, 32'(nover), 0);
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        ndone += int'(bus4.done);
      end
      chk({vecs[i].nm, "_extra_done"}, 32'(ndone), 0);
      chk({vecs[i].nm, "_held"}, 32'(bus4.product),
          32'(vecs[i].p));
    end

    // start held high: three back-to-back operations
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a_in  = ca[0];
    bus4.b_in  = cb[0];
    last = -1;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      @(posedge clk); #1;
      while (!bus4.done && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      chk("cont_done_seen", 32'(bus4.done), 1);
      chk("cont_product", 32'(bus4.product), 32'(cp[k]));
      if (k > 0) chk("cont_period", 32'(cyc - last), 7);
      last = cyc;
      if (k < 2) begin
        bus4.a_in = ca[k+1];
        bus4.b_in = cb[k+1];
      end else begin
        bus4.start = 1'b0;
      end
    end
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      ndone += int'(bus4.done);
    end
    chk("cont_no_fourth", 32'(ndone), 0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a_in  = 4'd7;
    bus4.b_in  = 4'd7;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_ctrl", 32'(bus4.dp_ctrl), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus4.busy), 0);
    chk("arst_ctrl", 32'(bus4.dp_ctrl), 0);
    chk("arst_load", 32'(bus4.dp_load), 0);
    chk("arst_done", 32'(bus4.done), 0);
    chk("arst_product", 32'(bus4.product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(4'd2, 4'd3, 1'b0, prod, lat, nbusy, nctrl, nover);
    chk("post_rst_product", 32'(prod), 6);
    chk("post_rst_latency", 32'(lat), 6);

    // WIDTH=8 instance
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a_in  = 8'd255;
    bus8.b_in  = 8'd255;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus8.done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("w8_latency", 32'(lat), 10);
    chk("w8_product", 32'(bus8.product), 32'h0000FE01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
